// File: rtl/voice_mix_sequencer_pkg.sv
// synth_pkg: state encoding, width helpers and the sample width default
// shared by the voice mix sequencer, its engine interface and the scaler.
package synth_pkg;

    // Schedule states; encoding is exposed on the debug port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SAMPLE_W_DEF = 16;

    // Width of a voice index.
    function automatic int vw(input int n);
        return $clog2(n);
    endfunction

    // Accumulator width: one full sample per voice cannot overflow.
    function automatic int aw(input int sample_w, input int n);
        return sample_w + vw(n);
    endfunction

endpackage

// File: rtl/voice_mix_sequencer_if.sv
// Request/acknowledge bus between the mix sequencer and the shared voice engine.
// Handshake: eng_req stays high with a stable eng_voice until the engine
// answers with eng_ack for exactly one cycle; eng_sample is valid only in
// that ack cycle. An ack while eng_req is low carries no meaning.
interface voice_mix_sequencer_if import synth_pkg::*; #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = SAMPLE_W_DEF
);
    localparam int VW = vw(NUM_VOICES);

    logic                eng_req;
    logic [VW-1:0]       eng_voice;
    logic                eng_ack;
    logic [SAMPLE_W-1:0] eng_sample;

    modport master (
        output eng_req,
        output eng_voice,
        input  eng_ack,
        input  eng_sample
    );

    modport slave (
        input  eng_req,
        input  eng_voice,
        output eng_ack,
        output eng_sample
    );

endinterface

// File: rtl/voice_mix_sequencer_mix_scaler.sv
// mix_scaler: arithmetic right shift of the mix accumulator and reduction
// to the output sample width.
// VOICE_MIX_SATURATE_EN defined: clamp to the signed SAMPLE_W range.
// VOICE_MIX_SATURATE_EN undefined: keep the low SAMPLE_W bits (wrap).
module mix_scaler #(
    parameter int AW         = 19,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_SHIFT = 3
) (
    input  logic signed [AW-1:0]       i_acc,
    output logic signed [SAMPLE_W-1:0] o_mix
);

`ifdef VOICE_MIX_SATURATE_EN
    logic signed [AW-1:0] w_shifted;
    logic                 w_fits;

    assign w_shifted = i_acc >>> GAIN_SHIFT;
    // Value fits when every bit above the output sign bit repeats the sign.
    assign w_fits = (w_shifted[AW-1:SAMPLE_W-1] == {(AW-SAMPLE_W+1){w_shifted[AW-1]}});

    // Pass through when in range, otherwise clamp toward the sign.
    always_comb begin
        o_mix = w_shifted[SAMPLE_W-1:0];
        if (!w_fits) begin
            o_mix = w_shifted[AW-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                    : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
    end
`else
    assign o_mix = SAMPLE_W'(i_acc >>> GAIN_SHIFT);
`endif

endmodule

// File: rtl/voice_mix_sequencer.sv
// voice_mix_sequencer: on each sample tick, walks the voice slots, fetches
// one sample per active voice from the shared engine, accumulates them and
// emits one scaled mix sample with a single-cycle valid strobe.
// Build option: VOICE_MIX_SATURATE_EN selects clamping instead of wrapping
// (handled inside mix_scaler).
module voice_mix_sequencer import synth_pkg::*; #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int GAIN_SHIFT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic [NUM_VOICES-1:0]      voice_active,
    voice_mix_sequencer_if.master      eng,
    output logic                       mix_valid,
    output logic signed [SAMPLE_W-1:0] mix_out,
    output logic                       busy,
    output logic                       overrun,
    input  logic                       overrun_clr,
    output state_t                     dbg_state
);

    localparam int            VW       = vw(NUM_VOICES);
    localparam int            AW       = aw(SAMPLE_W, NUM_VOICES);
    localparam logic [VW-1:0] LAST_IDX = VW'(NUM_VOICES - 1);

    state_t                      r_state;
    state_t                      w_next;
    logic [NUM_VOICES-1:0]       r_mask;
    logic [VW-1:0]               r_idx;
    logic signed [AW-1:0]        r_acc;
    logic                        r_mix_valid;
    logic signed [SAMPLE_W-1:0]  r_mix_out;
    logic                        r_overrun;

    logic                        w_is_last;
    logic                        w_got_ack;
    logic                        w_tick_busy;
    logic signed [AW-1:0]        w_sample_ext;
    logic signed [SAMPLE_W-1:0]  w_scaled;

    assign w_is_last    = (r_idx == LAST_IDX);
    assign w_got_ack    = (r_state == REQ) && eng.eng_ack;
    assign w_tick_busy  = tick && (r_state != IDLE);
    assign w_sample_ext = {{VW{eng.eng_sample[SAMPLE_W-1]}}, eng.eng_sample};

    mix_scaler #(
        .AW         (AW),
        .SAMPLE_W   (SAMPLE_W),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_scaler (
        .i_acc (r_acc),
        .o_mix (w_scaled)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: scan slots, wait for ack on active ones, finish after the last slot.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (tick) w_next = SCAN;
            SCAN: begin
                if (r_mask[r_idx]) begin
                    w_next = REQ;
                end else if (w_is_last) begin
                    w_next = DONE;
                end
            end
            REQ:  if (eng.eng_ack) w_next = w_is_last ? DONE : SCAN;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Schedule datapath: mask snapshot, slot index and running sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
            r_idx  <= '0;
            r_acc  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (tick) begin
                        r_mask <= voice_active;
                        r_idx  <= '0;
                        r_acc  <= '0;
                    end
                end
                SCAN: begin
                    if (!r_mask[r_idx] && !w_is_last) r_idx <= r_idx + 1'b1;
                end
                REQ: begin
                    if (w_got_ack) begin
                        r_acc <= r_acc + w_sample_ext;
                        if (!w_is_last) r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered mix output, strobe and sticky overrun flag (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mix_valid <= 1'b0;
            r_mix_out   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_mix_valid <= (r_state == DONE);
            if (r_state == DONE) r_mix_out <= w_scaled;
            if (w_tick_busy) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Moore outputs decoded from state and slot index.
    always_comb begin
        eng.eng_req   = (r_state == REQ);
        eng.eng_voice = (r_state == REQ) ? r_idx : '0;
        busy          = (r_state != IDLE);
        mix_valid     = r_mix_valid;
        mix_out       = r_mix_out;
        overrun       = r_overrun;
        dbg_state     = r_state;
    end

endmodule

// File: tb/tb_voice_mix_sequencer.sv
// Directed bench for voice_mix_sequencer: two instances (gain shift 3 and 0)
// share stimulus and a small engine responder with configurable ack latency.
module tb_voice_mix_sequencer;
    import synth_pkg::*;

    localparam int N  = 8;
    localparam int SW = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        overrun_clr = 1'b0;
    logic [7:0]  voice_active = 8'h00;
    logic        ack = 1'b0;
    logic [15:0] sample = 16'h0000;

    logic        mv3, busy3, ovr3, mv0, busy0, ovr0;
    logic [15:0] mo3, mo0;
    state_t      st3, st0;

    voice_mix_sequencer_if #(.NUM_VOICES(N), .SAMPLE_W(SW)) if3 ();
    voice_mix_sequencer_if #(.NUM_VOICES(N), .SAMPLE_W(SW)) if0 ();

    assign if3.eng_ack    = ack;
    assign if3.eng_sample = sample;
    assign if0.eng_ack    = ack;
    assign if0.eng_sample = sample;

    // Clock generation.
    always #5 clk = ~clk;

    voice_mix_sequencer #(.NUM_VOICES(N), .SAMPLE_W(SW), .GAIN_SHIFT(3)) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .voice_active (voice_active),
        .eng          (if3),
        .mix_valid    (mv3),
        .mix_out      (mo3),
        .busy         (busy3),
        .overrun      (ovr3),
        .overrun_clr  (overrun_clr),
        .dbg_state    (st3)
    );

    voice_mix_sequencer #(.NUM_VOICES(N), .SAMPLE_W(SW), .GAIN_SHIFT(0)) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .voice_active (voice_active),
        .eng          (if0),
        .mix_valid    (mv0),
        .mix_out      (mo0),
        .busy         (busy0),
        .overrun      (ovr0),
        .overrun_clr  (overrun_clr),
        .dbg_state    (st0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Engine model state.
    logic [15:0] samp_tbl [8];
    int          ack_wait = 0;
    int          wait_cnt = 0;
    logic [2:0]  held_voice = 3'd0;
    int          req_log [$];
    int          req_cycles = 0;
    int          mv_count = 0;

    // Engine responder: acks after ack_wait idle request cycles, checks that
    // the request holds its voice while waiting, and tallies strobes.
    initial begin
        forever begin
            @(negedge clk);
            ack = 1'b0;
            if (if3.eng_req) begin
                req_cycles++;
                if (wait_cnt > 0) check("req_voice_stable", 32'(if3.eng_voice), 32'(held_voice));
                else held_voice = if3.eng_voice;
                if (wait_cnt >= ack_wait) begin
                    ack      = 1'b1;
                    sample   = samp_tbl[if3.eng_voice];
                    req_log.push_back(int'(if3.eng_voice));
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            if (mv3) mv_count++;
        end
    end

    // Issue one accepted tick, scramble voice_active afterwards, and return
    // the cycle (tick cycle = 0) in which mix_valid is seen.
    task automatic do_tick(input logic [7:0] act, output int vcyc);
        @(negedge clk);
        voice_active = act;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        voice_active = ~act;
        vcyc = 1;
        while (!mv3 && vcyc < 200) begin
            @(negedge clk);
            vcyc++;
        end
    endtask

    // Hard time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int vc;
    int mv_before;
    int rq_before;

    initial begin
        for (int i = 0; i < 8; i++) samp_tbl[i] = 16'd0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_eng_req",   32'(if3.eng_req), 0);
        check("rst_eng_voice", 32'(if3.eng_voice), 0);
        check("rst_mix_valid", 32'(mv3), 0);
        check("rst_mix_out",   32'(mo3), 0);
        check("rst_busy",      32'(busy3), 0);
        check("rst_overrun",   32'(ovr3), 0);
        check("rst_state",     32'(st3), 32'(IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All voices active, zero-wait ack, every sample 100
        for (int i = 0; i < 8; i++) samp_tbl[i] = 16'd100;
        ack_wait = 0;
        req_log.delete();
        do_tick(8'hFF, vc);
        check("t1_valid_cycle", vc, 18);
        check("t1_mix_out",     32'(mo3), 100);
        check("t1_mix_out_g0",  32'(mo0), 800);
        check("t1_req_count",   req_log.size(), 8);
        for (int i = 0; i < req_log.size(); i++) check("t1_req_voice", req_log[i], i);
        @(negedge clk);
        check("t1_valid_one_cycle", 32'(mv3), 0);
        check("t1_idle_after", 32'(busy3), 0);

        // Sparse mask 0000_0101, two-cycle ack wait
        samp_tbl[0] = 16'd1000;
        samp_tbl[2] = 16'hFF38;
        ack_wait = 2;
        req_log.delete();
        do_tick(8'h05, vc);
        check("t2_valid_cycle", vc, 16);
        check("t2_mix_out",     32'(mo3), 100);
        check("t2_mix_out_g0",  32'(mo0), 800);
        check("t2_req_count",   req_log.size(), 2);
        if (req_log.size() == 2) begin
            check("t2_req_voice0", req_log[0], 0);
            check("t2_req_voice1", req_log[1], 2);
        end

        // Full-scale samples: saturate versus wrap at gain shift 0
        for (int i = 0; i < 8; i++) samp_tbl[i] = 16'h7FFF;
        ack_wait = 0;
        do_tick(8'hFF, vc);
        check("t3_valid_cycle", vc, 18);
        check("t3_mix_out_g3",  32'(mo3), 32'h7FFF);
`ifdef VOICE_MIX_SATURATE_EN
        check("t3_mix_out_g0",  32'(mo0), 32'h7FFF);
`else
        check("t3_mix_out_g0",  32'(mo0), 32'hFFF8);
`endif

        // Overrun: dropped ticks, clear, set-wins, tick during DONE
        for (int i = 0; i < 8; i++) samp_tbl[i] = 16'd100;
        @(negedge clk);
        check("t4_ovr_initial", 32'(ovr3), 0);
        mv_before = mv_count;
        voice_active = 8'hFF;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            case (c)
                6:  check("t4_ovr_set",      32'(ovr3), 1);
                8:  check("t4_ovr_clr",      32'(ovr3), 0);
                11: check("t4_set_wins",     32'(ovr3), 1);
                13: check("t4_ovr_clr2",     32'(ovr3), 0);
                17: check("t4_state_done",   32'(st3), 32'(DONE));
                18: begin
                    check("t4_ovr_done_tick", 32'(ovr3), 1);
                    check("t4_valid_cycle",   32'(mv3), 1);
                end
                default: ;
            endcase
            tick        = (c == 5) || (c == 10) || (c == 17);
            overrun_clr = (c == 7) || (c == 10) || (c == 12);
            @(negedge clk);
        end
        tick = 1'b0;
        overrun_clr = 1'b0;
        repeat (30) @(negedge clk);
        check("t4_one_valid", mv_count - mv_before, 1);
        check("t4_mix_out",   32'(mo3), 100);
        check("t4_idle",      32'(busy3), 0);

        // Reset while waiting in REQ
        ack_wait = 1000;
        mv_before = mv_count;
        @(negedge clk);
        voice_active = 8'hFF;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        check("t5_req_before_rst", 32'(if3.eng_req), 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_req_async_drop", 32'(if3.eng_req), 0);
        check("t5_busy_async",     32'(busy3), 0);
        check("t5_ovr_cleared",    32'(ovr3), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_wait = 0;
        repeat (25) @(negedge clk);
        check("t5_no_valid", mv_count - mv_before, 0);
        do_tick(8'h03, vc);
        check("t5_clean_cycle",   vc, 12);
        check("t5_clean_mix",     32'(mo3), 25);
        check("t5_clean_mix_g0",  32'(mo0), 200);

        // No voices active
        rq_before = req_cycles;
        do_tick(8'h00, vc);
        check("t6_valid_cycle", vc, 10);
        check("t6_mix_out",     32'(mo3), 0);
        check("t6_no_req",      req_cycles - rq_before, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
